// File: rtl/vce_frame_capture.sv
// VCE video capture: samples 3:3:3 RGB and sync on pixel enables, tracks raster
// position and queues active-window pixels as linear framebuffer writes.
module vce_frame_capture #(
   parameter int H_SKIP     = 40,
   parameter int H_ACTIVE   = 256,
   parameter int V_SKIP     = 14,
   parameter int V_ACTIVE   = 240,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 17
) (
   input  logic              clock,
   input  logic              reset_N,
   input  logic              clock_en,
   input  logic [2:0]        VIDEO_R,
   input  logic [2:0]        VIDEO_G,
   input  logic [2:0]        VIDEO_B,
   input  logic              HSYNC_n,
   input  logic              VSYNC_n,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [8:0]        fb_data,
   output logic              fb_valid,
   input  logic              fb_ready,
   output logic              frame_done,
   output logic              overflow,
   output logic              locked
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {WAIT_VSYNC = 1'b0, ACTIVE = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              hs_prev_q, hs_prev_d;
   logic              vs_prev_q, vs_prev_d;
   logic [9:0]        h_cnt_q, h_cnt_d;
   logic [8:0]        v_cnt_q, v_cnt_d;
   logic              frame_done_q, frame_done_d;
   logic              overflow_q, overflow_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
   logic [8:0]        mem_data_q [FIFO_DEPTH];

   logic              vs_fall, hs_fall, in_window;
   logic              push_req, push, pop, full;
   logic [ADDR_W-1:0] pix_addr;
   logic [8:0]        pix_data;

   assign fb_valid   = (count_q != '0);
   assign fb_addr    = fb_valid ? mem_addr_q[rd_ptr_q] : '0;
   assign fb_data    = fb_valid ? mem_data_q[rd_ptr_q] : '0;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign locked     = (state_q == ACTIVE);

   always_comb begin
      state_d      = state_q;
      hs_prev_d    = hs_prev_q;
      vs_prev_d    = vs_prev_q;
      h_cnt_d      = h_cnt_q;
      v_cnt_d      = v_cnt_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;

      vs_fall   = clock_en && vs_prev_q && !VSYNC_n;
      hs_fall   = clock_en && hs_prev_q && !HSYNC_n;
      in_window = (int'(h_cnt_q) >= H_SKIP) && (int'(h_cnt_q) < H_SKIP + H_ACTIVE) &&
                  (int'(v_cnt_q) >= V_SKIP) && (int'(v_cnt_q) < V_SKIP + V_ACTIVE);
      pix_addr  = (ADDR_W'(v_cnt_q) - ADDR_W'(V_SKIP)) * ADDR_W'(H_ACTIVE) +
                  (ADDR_W'(h_cnt_q) - ADDR_W'(H_SKIP));
      pix_data  = {VIDEO_R, VIDEO_G, VIDEO_B};
      // Window test uses the counters as they stood before this sample's update.
      push_req  = clock_en && !vs_fall && !hs_fall && (state_q == ACTIVE) && in_window;

      if (clock_en) begin
         hs_prev_d = HSYNC_n;
         vs_prev_d = VSYNC_n;
         if (vs_fall) begin
            h_cnt_d      = '0;
            v_cnt_d      = '0;
            frame_done_d = 1'b1;
            state_d      = ACTIVE;
         end else if (hs_fall) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == '1) ? v_cnt_q : v_cnt_q + 9'd1;
         end else begin
            h_cnt_d = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 10'd1;
         end
      end

      pop  = fb_valid && fb_ready;
      full = (count_q == DEPTH_C);
      // A full FIFO still takes a pixel when the head leaves in the same clock.
      push = push_req && (!full || pop);
      if (push_req && !push) overflow_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_N) begin
         state_q      <= WAIT_VSYNC;
         hs_prev_q    <= 1'b1;
         vs_prev_q    <= 1'b1;
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         hs_prev_q    <= hs_prev_d;
         vs_prev_q    <= vs_prev_d;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_addr_q[wr_ptr_q] <= pix_addr;
         mem_data_q[wr_ptr_q] <= pix_data;
      end
   end

endmodule

// File: tb/tb_vce_frame_capture.sv
// Bench for vce_frame_capture: directed raster scenarios plus a randomized run
// against a queue-based reference of the capture window and write FIFO.
module tb_vce_frame_capture;
   localparam int HS = 2, HA = 4, VS = 1, VA = 2, DEPTH = 4, AW = 17;

   logic          clock = 1'b0;
   logic          reset_N, clock_en, HSYNC_n, VSYNC_n, fb_ready;
   logic [2:0]    VIDEO_R, VIDEO_G, VIDEO_B;
   logic [AW-1:0] fb_addr;
   logic [8:0]    fb_data;
   logic          fb_valid, frame_done, overflow, locked;

   int checks = 0, failures = 0;

   // Reference state: raster position, lock, flags and queued writes (addr*512+data).
   int m_h = 0, m_v = 0;
   bit m_hprev = 1, m_vprev = 1, m_locked = 0, m_fd = 0, m_ovf = 0;
   int mq[$];
   int got_q[$];
   int fd_cnt = 0;

   vce_frame_capture #(.H_SKIP(HS), .H_ACTIVE(HA), .V_SKIP(VS), .V_ACTIVE(VA),
                       .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clock(clock), .reset_N(reset_N), .clock_en(clock_en),
      .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
      .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_valid(fb_valid), .fb_ready(fb_ready),
      .frame_done(frame_done), .overflow(overflow), .locked(locked));

   always #5 clock = ~clock;

   task automatic tick();
      bit pop, push, vf, hf, fd_n;
      int ent;
      if (reset_N && fb_valid && fb_ready) got_q.push_back(int'(fb_addr) * 512 + int'(fb_data));
      if (!reset_N) begin
         mq.delete();
         m_h = 0; m_v = 0; m_hprev = 1; m_vprev = 1;
         m_locked = 0; m_fd = 0; m_ovf = 0;
      end else begin
         pop  = (mq.size() > 0) && fb_ready;
         push = 0; ent = 0; fd_n = 0;
         if (clock_en) begin
            vf = m_vprev && !VSYNC_n;
            hf = m_hprev && !HSYNC_n;
            if (vf) begin
               m_h = 0; m_v = 0; m_locked = 1; fd_n = 1;
            end else if (hf) begin
               m_h = 0; m_v = (m_v < 511) ? m_v + 1 : 511;
            end else begin
               if (m_locked && m_h >= HS && m_h < HS + HA && m_v >= VS && m_v < VS + VA) begin
                  push = 1;
                  ent  = ((((m_v - VS) * HA + (m_h - HS)) & ((1 << AW) - 1)) * 512) +
                         {VIDEO_R, VIDEO_G, VIDEO_B};
               end
               m_h = (m_h < 1023) ? m_h + 1 : 1023;
            end
            m_hprev = HSYNC_n;
            m_vprev = VSYNC_n;
         end
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < DEPTH) mq.push_back(ent);
            else m_ovf = 1;
         end
         m_fd = fd_n;
      end
      @(posedge clock);
      #1;
      if (frame_done) fd_cnt++;
   endtask

   task automatic set_pix(bit hs, bit vs, int rgb);
      HSYNC_n = hs;
      VSYNC_n = vs;
      {VIDEO_R, VIDEO_G, VIDEO_B} = rgb[8:0];
   endtask

   task automatic sample(bit hs, bit vs, int rgb);
      set_pix(hs, vs, rgb);
      clock_en = 1'b1;
      tick();
      clock_en = 1'b0;
      tick();
   endtask

   task automatic line();
      sample(1'b0, 1'b1, 0);
      for (int k = 0; k < 8; k++) sample(1'b1, 1'b1, k);
   endtask

   task automatic idle(int n);
      clock_en = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset_N = 1'b0; clock_en = 1'b0;
      set_pix(1'b1, 1'b1, 0);
      tick(); tick();
      reset_N = 1'b1;
      got_q.delete();
      fd_cnt = 0;
   endtask

   task automatic test_reset();
      reset_N = 1'b0; clock_en = 1'b1; fb_ready = 1'b1;
      set_pix(1'b0, 1'b0, 9'h1ff);
      tick(); tick();
      checks++; if (fb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", fb_valid); end
      checks++; if (fb_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", fb_addr); end
      checks++; if (fb_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", fb_data); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
      do_reset();
   endtask

   task automatic test_prelock();
      do_reset();
      fb_ready = 1'b1;
      for (int l = 0; l < 2; l++) begin
         sample(1'b0, 1'b1, 0);
         for (int k = 0; k < 8; k++) begin
            sample(1'b1, 1'b1, k);
            checks++; if (fb_valid !== 1'b0) begin failures++; $display("FAIL prelock_valid got=%0b exp=0", fb_valid); end
         end
      end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL prelock_locked got=%0b exp=0", locked); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL prelock_overflow got=%0b exp=0", overflow); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL prelock_writes got=%0d exp=0", got_q.size()); end
   endtask

   task automatic test_frame();
      do_reset();
      fb_ready = 1'b1;
      sample(1'b1, 1'b0, 0);
      line(); line();
      idle(6);
      checks++; if (got_q.size() != 8) begin failures++; $display("FAIL frame_count got=%0d exp=8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         checks++; if (got_q[i] / 512 != i) begin failures++; $display("FAIL frame_addr[%0d] got=%0d exp=%0d", i, got_q[i] / 512, i); end
         checks++; if (got_q[i] % 512 != 2 + i % 4) begin failures++; $display("FAIL frame_data[%0d] got=%0d exp=%0d", i, got_q[i] % 512, 2 + i % 4); end
      end
      checks++; if (fd_cnt != 1) begin failures++; $display("FAIL frame_done_pulses got=%0d exp=1", fd_cnt); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL frame_locked got=%0b exp=1", locked); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL frame_overflow got=%0b exp=0", overflow); end
      checks++; if (fb_valid !== 1'b0) begin failures++; $display("FAIL frame_drained got=%0b exp=0", fb_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      fb_ready = 1'b0;
      sample(1'b1, 1'b0, 0);
      sample(1'b0, 1'b1, 0);
      for (int k = 0; k < 8; k++) begin
         sample(1'b1, 1'b1, k);
         if (k >= 2) begin
            checks++; if (fb_valid !== 1'b1 || fb_addr !== 17'd0 || fb_data !== 9'd2) begin
               failures++; $display("FAIL ovf_hold v=%0b addr=%0d data=%0d exp v=1 addr=0 data=2", fb_valid, fb_addr, fb_data); end
         end
      end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", overflow); end
      sample(1'b0, 1'b1, 0);
      for (int k = 0; k < 3; k++) sample(1'b1, 1'b1, k);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
      checks++; if (fb_addr !== 17'd0) begin failures++; $display("FAIL ovf_head got=%0d exp=0", fb_addr); end
      fb_ready = 1'b1;
      idle(10);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
         checks++; if (got_q[i] / 512 != i) begin failures++; $display("FAIL ovf_drain_addr[%0d] got=%0d exp=%0d", i, got_q[i] / 512, i); end
      end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fb_ready = 1'b0;
      sample(1'b1, 1'b0, 0);
      sample(1'b0, 1'b1, 0);
      for (int k = 0; k < 6; k++) sample(1'b1, 1'b1, k);
      sample(1'b0, 1'b1, 0);
      sample(1'b1, 1'b1, 0);
      sample(1'b1, 1'b1, 1);
      set_pix(1'b1, 1'b1, 7);
      clock_en = 1'b1; fb_ready = 1'b1;
      tick();
      clock_en = 1'b0; fb_ready = 1'b0;
      tick();
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%0b exp=0", overflow); end
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL b2b_popped got=%0d exp=1", got_q.size()); end
      checks++; if (fb_addr !== 17'd1) begin failures++; $display("FAIL b2b_head got=%0d exp=1", fb_addr); end
      got_q.delete();
      fb_ready = 1'b1;
      idle(8);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL b2b_occupancy got=%0d exp=4", got_q.size()); end
      if (got_q.size() == 4) begin
         checks++; if (got_q[3] != 4 * 512 + 7) begin failures++; $display("FAIL b2b_last got=%0d exp=%0d", got_q[3], 4 * 512 + 7); end
      end
   endtask

   task automatic test_simul_sync();
      do_reset();
      fb_ready = 1'b1;
      sample(1'b0, 1'b0, 0);
      for (int k = 0; k < 8; k++) sample(1'b1, 1'b1, k);
      line();
      idle(4);
      checks++; if (fd_cnt != 1) begin failures++; $display("FAIL simul_frame_done got=%0d exp=1", fd_cnt); end
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL simul_count got=%0d exp=4", got_q.size()); end
      if (got_q.size() > 0) begin
         checks++; if (got_q[0] != 2) begin failures++; $display("FAIL simul_first got=%0d exp=2", got_q[0]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fb_ready = 1'b0;
      sample(1'b1, 1'b0, 0);
      sample(1'b0, 1'b1, 0);
      for (int k = 0; k < 5; k++) sample(1'b1, 1'b1, k);
      checks++; if (fb_valid !== 1'b1) begin failures++; $display("FAIL mid_queued got=%0b exp=1", fb_valid); end
      reset_N = 1'b0;
      tick();
      reset_N = 1'b1;
      checks++; if (fb_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", fb_valid); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_locked got=%0b exp=0", locked); end
      fb_ready = 1'b1;
      got_q.delete();
      line(); line();
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL mid_nocapture got=%0d exp=0", got_q.size()); end
      sample(1'b1, 1'b0, 0);
      line();
      idle(4);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL mid_resume got=%0d exp=4", got_q.size()); end
      if (got_q.size() > 0) begin
         checks++; if (got_q[0] / 512 != 0) begin failures++; $display("FAIL mid_resume_addr got=%0d exp=0", got_q[0] / 512); end
      end
   endtask

   task automatic test_random();
      int exp_a, exp_d;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset_N  = (i != 1500);
         clock_en = 1'($urandom_range(0, 1));
         set_pix($urandom_range(0, 9) != 0, $urandom_range(0, 199) != 0, int'($urandom_range(0, 511)));
         fb_ready = ($urandom_range(0, 3) != 0);
         tick();
         exp_a = (mq.size() > 0) ? mq[0] / 512 : 0;
         exp_d = (mq.size() > 0) ? mq[0] % 512 : 0;
         checks++; if (fb_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, fb_valid, mq.size() > 0); end
         if (mq.size() > 0) begin
            checks++; if (int'(fb_addr) != exp_a || int'(fb_data) != exp_d) begin
               failures++; $display("FAIL rnd_head cyc=%0d got=%0d/%0d exp=%0d/%0d", i, fb_addr, fb_data, exp_a, exp_d); end
         end
         checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%0b exp=%0b", i, overflow, m_ovf); end
         checks++; if (locked !== m_locked) begin failures++; $display("FAIL rnd_locked cyc=%0d got=%0b exp=%0b", i, locked, m_locked); end
         checks++; if (frame_done !== m_fd) begin failures++; $display("FAIL rnd_frame_done cyc=%0d got=%0b exp=%0b", i, frame_done, m_fd); end
      end
      reset_N = 1'b1;
   endtask

   initial begin
      reset_N = 1'b0; clock_en = 1'b0; fb_ready = 1'b1;
      set_pix(1'b1, 1'b1, 0);
      test_reset();
      test_prelock();
      test_frame();
      test_overflow();
      test_back_to_back();
      test_simul_sync();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
